// File: rtl/debug_retire_trace.sv
// -----------------------------------------------------------------------------
// debug_retire_trace
//
// Debug-only retire trace buffer that sits after the MEM/WB debug register.
// Each non-bubble, non-stalled WB slot is a retire. Every retire gets a
// sequence number. It is queued in a show-ahead FIFO that a valid/ready reader
// drains. A retire that arrives while the FIFO is full is dropped. It is still
// counted and still consumes a sequence number, so the reader sees a gap in
// the sequence wherever entries were lost.
//
// Ports:
//   i_clock        clock, all state updates on rising edge
//   i_reset        synchronous reset, active-low
//   i_stall        WB stalled; current slot is not a retire
//   i_clear        synchronous clear of FIFO, counters and sticky flag
//   i_dbgTick      tick number of instruction in WB
//   i_dbgInst      instruction in WB (0 = bubble)
//   o_traceValid   FIFO head valid
//   i_traceReady   reader accepts head
//   o_traceSeq     head retire sequence number
//   o_traceTick    head tick
//   o_traceInst    head instruction
//   o_level        entries currently held
//   o_retired      total retires seen (accepted + dropped)
//   o_dropped      retires lost to a full FIFO, saturating
//   o_overflow     sticky: at least one drop since reset/clear
// -----------------------------------------------------------------------------
module debug_retire_trace #(
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_stall,
    input  logic                  i_clear,
    input  logic [31:0]           i_dbgTick,
    input  logic [31:0]           i_dbgInst,
    output logic                  o_traceValid,
    input  logic                  i_traceReady,
    output logic [CNT_WIDTH-1:0]  o_traceSeq,
    output logic [31:0]           o_traceTick,
    output logic [31:0]           o_traceInst,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [CNT_WIDTH-1:0]  o_retired,
    output logic [CNT_WIDTH-1:0]  o_dropped,
    output logic                  o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Saturating increment used for the drop counter only.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    // Entry storage is not reset. The head outputs are masked while empty,
    // so stale contents are never observable.
    logic [CNT_WIDTH-1:0] mem_seq  [DEPTH];
    logic [31:0]          mem_tick [DEPTH];
    logic [31:0]          mem_inst [DEPTH];

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_q;
    logic [CNT_WIDTH-1:0] seq_q;
    logic [CNT_WIDTH-1:0] retired_q;
    logic [CNT_WIDTH-1:0] dropped_q;
    logic                 overflow_q;

    logic not_empty;
    logic full;
    logic retire;
    logic pop;
    logic push;
    logic drop;

    // Full and empty come from the level counter. Pointer equality cannot
    // tell a full FIFO from an empty one.
    assign not_empty = (level_q != '0);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign retire    = !i_stall && (i_dbgInst != 32'd0);
    assign pop       = not_empty && i_traceReady;
    // When the FIFO is full, a same-cycle pop frees a slot for the retire.
    assign push      = retire && (!full || pop);
    assign drop      = retire && !push;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            retired_q  <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else if (i_clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            retired_q  <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            // A dropped retire still advances the sequence number, which
            // leaves a visible gap for the reader.
            if (retire) begin
                seq_q     <= seq_q + 1'b1;
                retired_q <= retired_q + 1'b1;
            end
            if (drop) begin
                dropped_q  <= sat_inc(dropped_q);
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem_seq[wr_ptr]  <= seq_q;
            mem_tick[wr_ptr] <= i_dbgTick;
            mem_inst[wr_ptr] <= i_dbgInst;
        end
    end

    assign o_traceValid = not_empty;
    assign o_traceSeq   = not_empty ? mem_seq[rd_ptr]  : '0;
    assign o_traceTick  = not_empty ? mem_tick[rd_ptr] : 32'd0;
    assign o_traceInst  = not_empty ? mem_inst[rd_ptr] : 32'd0;
    assign o_level      = level_q;
    assign o_retired    = retired_q;
    assign o_dropped    = dropped_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_debug_retire_trace.sv
// -----------------------------------------------------------------------------
// tb_debug_retire_trace
//
// Self-checking bench for debug_retire_trace. It runs a vector table, then
// hand-written corner sequences, then randomized traffic checked against a
// queue-based reference model.
// -----------------------------------------------------------------------------
module tb_debug_retire_trace;

    localparam int DEPTH = 16;
    localparam int CW    = 32;

    logic        clk = 1'b0;
    logic        rst_n, stall, clear, ready;
    logic [31:0] tick, inst;
    logic        valid;
    logic [CW-1:0] t_seq;
    logic [31:0] t_tick, t_inst;
    logic [4:0]  level;
    logic [CW-1:0] retired, dropped;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    debug_retire_trace #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .i_clock(clk), .i_reset(rst_n), .i_stall(stall), .i_clear(clear),
        .i_dbgTick(tick), .i_dbgInst(inst), .o_traceValid(valid),
        .i_traceReady(ready), .o_traceSeq(t_seq), .o_traceTick(t_tick),
        .o_traceInst(t_inst), .o_level(level), .o_retired(retired),
        .o_dropped(dropped), .o_overflow(overflow)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] seq;
        logic [31:0] tick;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_seq, m_ret, m_drop;
    logic        m_ovf;

    task automatic model_step(input logic r, input logic c, input logic s,
                              input logic [31:0] in, input logic [31:0] tk,
                              input logic rd);
        ent_t e;
        if (!r || c) begin
            mq.delete();
            m_seq = 0; m_ret = 0; m_drop = 0; m_ovf = 0;
        end else begin
            if (mq.size() > 0 && rd) void'(mq.pop_front());
            if (!s && in != 0) begin
                if (mq.size() < DEPTH) begin
                    e.seq = m_seq; e.tick = tk; e.inst = in;
                    mq.push_back(e);
                end else begin
                    if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
                    m_ovf = 1;
                end
                m_seq = m_seq + 1;
                m_ret = m_ret + 1;
            end
        end
    endtask

    // Drives one cycle, advances the model, and samples 1 ns after the edge.
    task automatic apply(input logic r, input logic c, input logic s,
                         input logic [31:0] in, input logic [31:0] tk,
                         input logic rd);
        rst_n = r; clear = c; stall = s; inst = in; tick = tk; ready = rd;
        model_step(r, c, s, in, tk, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] es, et, ei;
        es = 0; et = 0; ei = 0;
        if (mq.size() > 0) begin
            es = mq[0].seq; et = mq[0].tick; ei = mq[0].inst;
        end
        chk({tag, ".valid"},    64'(valid),    64'(mq.size() > 0));
        chk({tag, ".level"},    64'(level),    64'(mq.size()));
        chk({tag, ".retired"},  64'(retired),  64'(m_ret));
        chk({tag, ".dropped"},  64'(dropped),  64'(m_drop));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".seq"},      64'(t_seq),    64'(es));
        chk({tag, ".tick"},     64'(t_tick),   64'(et));
        chk({tag, ".inst"},     64'(t_inst),   64'(ei));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        r, c, s, rd;
        logic [31:0] in, tk;
        logic        e_valid;
        logic [4:0]  e_level;
        logic [31:0] e_ret, e_seq, e_tick, e_inst;
    } vec_t;

    vec_t vt[11];

    initial begin
        rst_n = 0; clear = 0; stall = 0; ready = 0; tick = 0; inst = 0;
        m_seq = 0; m_ret = 0; m_drop = 0; m_ovf = 0;

        //          r  c  s  rd  inst   tick  v  lvl ret seq tick inst
        vt[0]  = '{0, 0, 0, 0, 32'h0,  0,    0, 0,  0,  0,  0,  32'h0};
        vt[1]  = '{1, 0, 0, 0, 32'h13, 5,    1, 1,  1,  0,  5,  32'h13};
        vt[2]  = '{1, 0, 0, 0, 32'h0,  6,    1, 1,  1,  0,  5,  32'h13};
        vt[3]  = '{1, 0, 0, 0, 32'h93, 7,    1, 2,  2,  0,  5,  32'h13};
        vt[4]  = '{1, 0, 0, 1, 32'h0,  8,    1, 1,  2,  1,  7,  32'h93};
        vt[5]  = '{1, 0, 0, 1, 32'h0,  8,    0, 0,  2,  0,  0,  32'h0};
        vt[6]  = '{1, 0, 1, 0, 32'h33, 9,    0, 0,  2,  0,  0,  32'h0};
        vt[7]  = '{1, 0, 1, 0, 32'h33, 9,    0, 0,  2,  0,  0,  32'h0};
        vt[8]  = '{1, 0, 1, 0, 32'h33, 9,    0, 0,  2,  0,  0,  32'h0};
        vt[9]  = '{1, 0, 0, 0, 32'h33, 9,    1, 1,  3,  2,  9,  32'h33};
        vt[10] = '{1, 0, 0, 1, 32'h0,  10,   0, 0,  3,  0,  0,  32'h0};

        apply(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            apply(vt[i].r, vt[i].c, vt[i].s, vt[i].in, vt[i].tk, vt[i].rd);
            chk($sformatf("vec%0d.valid", i),   64'(valid),   64'(vt[i].e_valid));
            chk($sformatf("vec%0d.level", i),   64'(level),   64'(vt[i].e_level));
            chk($sformatf("vec%0d.retired", i), 64'(retired), 64'(vt[i].e_ret));
            chk($sformatf("vec%0d.seq", i),     64'(t_seq),   64'(vt[i].e_seq));
            chk($sformatf("vec%0d.tick", i),    64'(t_tick),  64'(vt[i].e_tick));
            chk($sformatf("vec%0d.inst", i),    64'(t_inst),  64'(vt[i].e_inst));
            chk($sformatf("vec%0d.dropped", i), 64'(dropped), 64'd0);
        end

        // ---------------- overflow: 18 retires into 16 slots ----------------
        apply(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) apply(1, 0, 0, 32'h1000 + i, 100 + i, 0);
        chk("ovf.level",    64'(level),    64'd16);
        chk("ovf.dropped",  64'(dropped),  64'd2);
        chk("ovf.overflow", 64'(overflow), 64'd1);
        chk("ovf.retired",  64'(retired),  64'd18);
        // Drain in order, seqs 0..15.
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d.seq", i),  64'(t_seq),  64'(i));
            chk($sformatf("drain%0d.tick", i), 64'(t_tick), 64'(100 + i));
            apply(1, 0, 0, 0, 0, 1);
        end
        chk("drain.empty", 64'(valid), 64'd0);
        apply(1, 0, 0, 32'h77, 200, 0);
        chk("gap.seq", 64'(t_seq), 64'd18);
        check_model("gap");

        // ---------------- full + retire + pop in same cycle ----------------
        for (int i = 0; i < 15; i++) apply(1, 0, 0, 32'h2000 + i, 300 + i, 0);
        chk("full.level", 64'(level), 64'd16);
        apply(1, 0, 0, 32'h55, 400, 1);
        chk("fullpop.level",   64'(level),   64'd16);
        chk("fullpop.dropped", 64'(dropped), 64'd2);
        chk("fullpop.retired", 64'(retired), 64'd35);
        chk("fullpop.headseq", 64'(t_seq),   64'd19);
        check_model("fullpop");

        // ---------------- clear with 5 queued entries ----------------
        apply(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply(1, 0, 0, 32'h3000 + i, 500 + i, 0);
        apply(1, 1, 0, 32'h99, 600, 1);
        chk("clr.valid",    64'(valid),    64'd0);
        chk("clr.level",    64'(level),    64'd0);
        chk("clr.retired",  64'(retired),  64'd0);
        chk("clr.dropped",  64'(dropped),  64'd0);
        chk("clr.overflow", 64'(overflow), 64'd0);
        apply(1, 0, 0, 32'hAB, 601, 0);
        chk("clr.nextseq",  64'(t_seq),    64'd0);
        chk("clr.nexttick", 64'(t_tick),   64'd601);

        // ---------------- reset mid-drain ----------------
        for (int i = 0; i < 8; i++) apply(1, 0, 0, 32'h4000 + i, 700 + i, 0);
        for (int i = 0; i < 4; i++) apply(1, 0, 0, 32'h5000 + i, 800 + i, logic'(i % 2));
        apply(0, 0, 0, 32'h66, 900, 1);
        chk("rst.valid",    64'(valid),    64'd0);
        chk("rst.level",    64'(level),    64'd0);
        chk("rst.retired",  64'(retired),  64'd0);
        chk("rst.dropped",  64'(dropped),  64'd0);
        chk("rst.overflow", 64'(overflow), 64'd0);
        chk("rst.seq",      64'(t_seq),    64'd0);
        chk("rst.inst",     64'(t_inst),   64'd0);
        check_model("rst");

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            logic r, c, s, rd;
            logic [31:0] in;
            r  = ($urandom_range(0, 499) != 0);
            c  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 4) == 0);
            in = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            // Alternate reader speed so the FIFO repeatedly fills and drains.
            if ((i / 200) % 2 == 0) rd = ($urandom_range(0, 4) == 0);
            else                    rd = ($urandom_range(0, 3) != 0);
            apply(r, c, s, in, $urandom, rd);
            check_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
